req_gnt_id_tracker: RTL and testbench

//  Synthesisable tracker for ID-tagged request/grant traffic. Records every request ID as outstanding.

---
 rtl/req_gnt_pkg.sv | 12 +
 rtl/req_gnt_entry.sv | 68 ++++++
 rtl/req_gnt_id_tracker.sv | 170 +++++++++++++++++
 tb/tb_req_gnt_id_tracker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_gnt_pkg.sv
// Shared types for the request/grant ID tracker.
// The error code reports the first fault seen since reset or clear.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DUP     = 2'd1,
    ERR_ORPHAN  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

endpackage

// File: rtl/req_gnt_entry.sv
// One tracked ID: pending flag, saturating age and, with
// REQ_GNT_TIMEOUT_EN defined, a once-per-request timeout bit.
module req_gnt_entry
  import req_gnt_pkg::*;
#(
  parameter int LAT_W   = 8
`ifdef REQ_GNT_TIMEOUT_EN
 ,parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic             rearm_i,
  output logic             pending_o,
  output logic [LAT_W-1:0] age_o
`ifdef REQ_GNT_TIMEOUT_EN
 ,output logic             timeout_o
`endif
);

  logic             pend_q;
  logic [LAT_W-1:0] age_q;
  logic [LAT_W-1:0] age_inc;

  assign age_inc = (&age_q) ? age_q : age_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      age_q  <= '0;
    end else if (rearm_i || set_i) begin
      pend_q <= 1'b1;
      age_q  <= LAT_W'(1);
    end else if (clr_i) begin
      pend_q <= 1'b0;
      age_q  <= '0;
    end else if (pend_q) begin
      age_q  <= age_inc;
    end
  end

`ifdef REQ_GNT_TIMEOUT_EN
  logic to_q;
  logic fire;

  // Only an ageing entry can time out; a retire or re-arm this cycle wins.
  assign fire = pend_q && !set_i && !clr_i && !rearm_i && !to_q
             && (age_inc == LAT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= 1'b0;
    end else if (rearm_i || set_i || clr_i) begin
      to_q <= 1'b0;
    end else if (fire) begin
      to_q <= 1'b1;
    end
  end

  assign timeout_o = fire;
`endif

  assign pending_o = pend_q;
  assign age_o     = age_q;

endmodule

// File: rtl/req_gnt_id_tracker.sv
// Tracks ID-tagged req/gnt traffic: latency, duplicate and orphan errors.
// Timeout detection is built only with REQ_GNT_TIMEOUT_EN defined.
module req_gnt_id_tracker
  import req_gnt_pkg::*;
#(
  parameter int ID_W    = 2,
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [ID_W-1:0]      req_id,
  input  logic                 gnt,
  input  logic [ID_W-1:0]      gnt_id,
  input  logic                 err_clr,
  output logic [(1<<ID_W)-1:0] pending,
  output logic [ID_W:0]        outstanding,
  output logic                 gnt_ok,
  output logic [LAT_W-1:0]     gnt_lat,
  output logic                 dup_req_err,
  output logic                 orphan_gnt_err,
  output logic                 timeout_err,
  output err_code_e            err_code,
  output logic [ID_W-1:0]      err_id
);

  localparam int NUM_IDS = 1 << ID_W;

  logic req_q, gnt_q, req_ev, gnt_ev;
  logic [NUM_IDS-1:0] pend, req_hit, gnt_hit;
  logic [NUM_IDS-1:0] set_v, clr_v, rearm_v;
  logic [LAT_W-1:0]   age [NUM_IDS];

  logic dup_ev, orphan_ev, good_gnt;
  logic dup_q, orphan_q, gnt_ok_q;
  logic [LAT_W-1:0] gnt_lat_q;
  err_code_e new_code, base_code, code_d, code_q;
  logic [ID_W-1:0] new_id, id_d, id_q;
  logic [ID_W:0] cnt;

  assign req_ev = req & ~req_q;
  assign gnt_ev = gnt & ~gnt_q;

  always_comb begin
    req_hit = '0;
    gnt_hit = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      req_hit[i] = req_ev && (req_id == ID_W'(i));
      gnt_hit[i] = gnt_ev && (gnt_id == ID_W'(i));
    end
  end

  // Grants are judged on the state before this edge.
  assign rearm_v   = req_hit & gnt_hit & pend;
  assign set_v     = req_hit & ~pend;
  assign clr_v     = gnt_hit & pend & ~rearm_v;
  assign dup_ev    = |(req_hit & pend & ~gnt_hit);
  assign orphan_ev = |(gnt_hit & ~pend);
  assign good_gnt  = |(gnt_hit & pend);

`ifdef REQ_GNT_TIMEOUT_EN
  logic [NUM_IDS-1:0] to_fire;
  logic [ID_W-1:0]    to_id;
  logic               to_ev, to_err_q;

  assign to_ev = |to_fire;

  always_comb begin
    to_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (to_fire[i]) to_id = ID_W'(i);
    end
  end
`endif

  for (genvar g = 0; g < NUM_IDS; g++) begin : g_entry
`ifdef REQ_GNT_TIMEOUT_EN
    req_gnt_entry #(.LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) u_entry (
      .clk(clk), .rst(rst),
      .set_i(set_v[g]), .clr_i(clr_v[g]), .rearm_i(rearm_v[g]),
      .pending_o(pend[g]), .age_o(age[g]), .timeout_o(to_fire[g])
    );
`else
    req_gnt_entry #(.LAT_W(LAT_W)) u_entry (
      .clk(clk), .rst(rst),
      .set_i(set_v[g]), .clr_i(clr_v[g]), .rearm_i(rearm_v[g]),
      .pending_o(pend[g]), .age_o(age[g])
    );
`endif
  end

  always_comb begin
    new_code = ERR_NONE;
    new_id   = '0;
    if (orphan_ev) begin
      new_code = ERR_ORPHAN;
      new_id   = gnt_id;
    end else if (dup_ev) begin
      new_code = ERR_DUP;
      new_id   = req_id;
    end
`ifdef REQ_GNT_TIMEOUT_EN
    else if (to_ev) begin
      new_code = ERR_TIMEOUT;
      new_id   = to_id;
    end
`endif
  end

  // A clear empties the capture slot, so a same-cycle error still lands.
  always_comb begin
    base_code = err_clr ? ERR_NONE : code_q;
    code_d    = base_code;
    id_d      = err_clr ? '0 : id_q;
    if (base_code == ERR_NONE && new_code != ERR_NONE) begin
      code_d = new_code;
      id_d   = new_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q     <= 1'b0;
      gnt_q     <= 1'b0;
      gnt_ok_q  <= 1'b0;
      gnt_lat_q <= '0;
      dup_q     <= 1'b0;
      orphan_q  <= 1'b0;
      code_q    <= ERR_NONE;
      id_q      <= '0;
    end else begin
      req_q     <= req;
      gnt_q     <= gnt;
      gnt_ok_q  <= good_gnt;
      if (good_gnt) gnt_lat_q <= age[gnt_id];
      dup_q     <= (dup_q & ~err_clr) | dup_ev;
      orphan_q  <= (orphan_q & ~err_clr) | orphan_ev;
      code_q    <= code_d;
      id_q      <= id_d;
    end
  end

`ifdef REQ_GNT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_err_q <= 1'b0;
    else     to_err_q <= (to_err_q & ~err_clr) | to_ev;
  end
  assign timeout_err = to_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_IDS; i++) begin
      cnt = cnt + {{ID_W{1'b0}}, pend[i]};
    end
  end

  assign pending        = pend;
  assign outstanding    = cnt;
  assign gnt_ok         = gnt_ok_q;
  assign gnt_lat        = gnt_lat_q;
  assign dup_req_err    = dup_q;
  assign orphan_gnt_err = orphan_q;
  assign err_code       = code_q;
  assign err_id         = id_q;

endmodule

// File: tb/tb_req_gnt_id_tracker.sv
// Bench for req_gnt_id_tracker: vector table through a scoreboard queue,
// plus hand sequences for saturation, async reset and timeout.
module tb_req_gnt_id_tracker;
  import req_gnt_pkg::*;

  logic       clk = 1'b0;
  logic       rst, req, gnt, err_clr;
  logic [1:0] req_id, gnt_id;
  logic [3:0] pending;
  logic [2:0] outstanding;
  logic       gnt_ok, dup_req_err, orphan_gnt_err, timeout_err;
  logic [7:0] gnt_lat;
  err_code_e  err_code;
  logic [1:0] err_id;

  int errors = 0;
  int checks = 0;

  req_gnt_id_tracker #(.ID_W(2), .LAT_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_id(req_id),
    .gnt(gnt), .gnt_id(gnt_id),
    .err_clr(err_clr),
    .pending(pending), .outstanding(outstanding),
    .gnt_ok(gnt_ok), .gnt_lat(gnt_lat),
    .dup_req_err(dup_req_err), .orphan_gnt_err(orphan_gnt_err),
    .timeout_err(timeout_err),
    .err_code(err_code), .err_id(err_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [1:0] rid;
    logic       gnt;
    logic [1:0] gid;
    logic       clr;
    logic [3:0] pend;
    logic       ok;
    logic [7:0] lat;
    logic       dup;
    logic       orph;
    logic [1:0] code;
    logic [1:0] eid;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];

  function automatic vec_t mk(
    logic r, logic [1:0] ri, logic g, logic [1:0] gi, logic c,
    logic [3:0] p, logic o, logic [7:0] l,
    logic d = 0, logic orp = 0, logic [1:0] cd = 0, logic [1:0] ei = 0);
    vec_t v;
    v.req = r; v.rid = ri; v.gnt = g; v.gid = gi; v.clr = c;
    v.pend = p; v.ok = o; v.lat = l;
    v.dup = d; v.orph = orp; v.code = cd; v.eid = ei;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic [1:0] ri, logic g,
                       logic [1:0] gi, logic c);
    req = r; req_id = ri; gnt = g; gnt_id = gi; err_clr = c;
  endtask

  initial begin
    vec_t e;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_gnt_ok", gnt_ok, 0);
    chk("rst_gnt_lat", gnt_lat, 0);
    chk("rst_errs", {dup_req_err, orphan_gnt_err, timeout_err}, 0);
    chk("rst_err_code", err_code, ERR_NONE);
    rst = 1'b0;

    // basic request/grant, latency 5
    vt.push_back(mk(1,2,0,0,0, 4'h4,0,0));
    repeat (4) vt.push_back(mk(1,2,0,0,0, 4'h4,0,0));
    vt.push_back(mk(1,2,1,2,0, 4'h0,1,5));
    vt.push_back(mk(0,0,0,0,0, 4'h0,0,5));
    // out-of-order grants
    vt.push_back(mk(1,2,0,0,0, 4'h4,0,5));
    vt.push_back(mk(0,0,0,0,0, 4'h4,0,5));
    vt.push_back(mk(1,3,0,0,0, 4'hC,0,5));
    vt.push_back(mk(0,0,1,3,0, 4'h4,1,1));
    vt.push_back(mk(0,0,0,0,0, 4'h4,0,1));
    vt.push_back(mk(0,0,1,2,0, 4'h0,1,5));
    vt.push_back(mk(0,0,0,0,0, 4'h0,0,5));
    // orphan then clear
    vt.push_back(mk(0,0,1,1,0, 4'h0,0,5, 0,1,2,1));
    vt.push_back(mk(0,0,0,0,1, 4'h0,0,5));
    // duplicate, age not restarted
    vt.push_back(mk(1,0,0,0,0, 4'h1,0,5));
    vt.push_back(mk(0,0,0,0,0, 4'h1,0,5));
    vt.push_back(mk(1,0,0,0,0, 4'h1,0,5, 1,0,1,0));
    vt.push_back(mk(0,0,0,0,0, 4'h1,0,5, 1,0,1,0));
    vt.push_back(mk(0,0,1,0,0, 4'h0,1,4, 1,0,1,0));
    vt.push_back(mk(0,0,0,0,1, 4'h0,0,4));
    // same-cycle req+gnt on pending id re-arms
    vt.push_back(mk(1,2,0,0,0, 4'h4,0,4));
    vt.push_back(mk(0,0,0,0,0, 4'h4,0,4));
    vt.push_back(mk(1,2,1,2,0, 4'h4,1,2));
    vt.push_back(mk(0,0,0,0,0, 4'h4,0,2));
    vt.push_back(mk(0,0,1,2,0, 4'h0,1,2));
    vt.push_back(mk(0,0,0,0,0, 4'h0,0,2));
    // same-cycle req+gnt on idle id: orphan and becomes pending
    vt.push_back(mk(1,1,1,1,0, 4'h2,0,2, 0,1,2,1));
    vt.push_back(mk(0,0,0,0,1, 4'h2,0,2));
    // orphan beats dup in the same cycle
    vt.push_back(mk(1,1,1,3,0, 4'h2,0,2, 1,1,2,3));
    vt.push_back(mk(0,0,0,0,1, 4'h2,0,2));
    // new error wins over clear
    vt.push_back(mk(1,1,0,0,1, 4'h2,0,2, 1,0,1,1));
    vt.push_back(mk(0,0,0,0,1, 4'h2,0,2));
    vt.push_back(mk(0,0,1,1,0, 4'h0,1,6));
    vt.push_back(mk(0,0,0,0,0, 4'h0,0,6));
    // first error held against a later one
    vt.push_back(mk(0,0,1,0,0, 4'h0,0,6, 0,1,2,0));
    vt.push_back(mk(0,0,0,0,0, 4'h0,0,6, 0,1,2,0));
    vt.push_back(mk(1,3,0,0,0, 4'h8,0,6, 0,1,2,0));
    vt.push_back(mk(0,0,0,0,0, 4'h8,0,6, 0,1,2,0));
    vt.push_back(mk(1,3,0,0,0, 4'h8,0,6, 1,1,2,0));
    vt.push_back(mk(0,0,0,0,1, 4'h8,0,6));
    vt.push_back(mk(0,0,1,3,0, 4'h0,1,4));
    vt.push_back(mk(0,0,0,0,0, 4'h0,0,4));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].req, vt[i].rid, vt[i].gnt, vt[i].gid, vt[i].clr);
      sb.push_back(vt[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_pending", i), pending, e.pend);
      chk($sformatf("v%0d_outstanding", i), outstanding,
          $countones(e.pend));
      chk($sformatf("v%0d_gnt_ok", i), gnt_ok, e.ok);
      chk($sformatf("v%0d_gnt_lat", i), gnt_lat, e.lat);
      chk($sformatf("v%0d_dup", i), dup_req_err, e.dup);
      chk($sformatf("v%0d_orphan", i), orphan_gnt_err, e.orph);
      chk($sformatf("v%0d_timeout", i), timeout_err, 0);
      chk($sformatf("v%0d_code", i), err_code, e.code);
      chk($sformatf("v%0d_err_id", i), err_id, e.eid);
    end

    // latency saturates at all-ones
    drive(1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    repeat (299) step();
    drive(0, 0, 1, 1, 0);
    step();
    chk("sat_gnt_ok", gnt_ok, 1);
    chk("sat_gnt_lat", gnt_lat, 8'hFF);
    chk("sat_pending", pending, 0);
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);

    // asynchronous reset mid-transaction
    drive(1, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk("pre_rst_pending", pending, 4'h2);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pending", pending, 0);
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_gnt_lat", gnt_lat, 0);
    #1 rst = 1'b0;
    step();
    drive(0, 0, 1, 1, 0);
    step();
    chk("post_rst_orphan", orphan_gnt_err, 1);
    chk("post_rst_gnt_ok", gnt_ok, 0);
    chk("post_rst_code", err_code, ERR_ORPHAN);
    chk("post_rst_err_id", err_id, 1);
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("post_clr_orphan", orphan_gnt_err, 0);

`ifdef REQ_GNT_TIMEOUT_EN
    drive(1, 3, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("to_early_%0d", i), timeout_err, 0);
      step();
    end
    chk("to_early_14", timeout_err, 0);
    step();
    chk("to_fire", timeout_err, 1);
    chk("to_code", err_code, ERR_TIMEOUT);
    chk("to_err_id", err_id, 3);
    chk("to_still_pending", pending, 4'h8);
    drive(0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_once_%0d", i), timeout_err, 0);
      step();
    end
    drive(0, 0, 1, 3, 0);
    step();
    chk("to_gnt_ok", gnt_ok, 1);
    chk("to_gnt_lat", gnt_lat, 21);
    chk("to_pending", pending, 0);
    chk("to_after_gnt", timeout_err, 0);
    drive(0, 0, 0, 0, 0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
